// File: rtl/noc_vc_input_buffer_if.sv
// Port bundle between the VC input buffer, its upstream link, the switch
// allocator's arbiter and the crossbar.
interface noc_vc_input_buffer_if #(
  parameter int CHANNELS = 12,
  parameter int FLIT_W   = 64
);
  localparam int VC_W = $clog2(CHANNELS);

  logic                in_valid;
  logic [VC_W-1:0]     in_vc;
  logic [1:0]          in_type;
  logic [FLIT_W-1:0]   in_flit;
  logic [CHANNELS-1:0] dn_ready;
  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] gnt;
  logic [CHANNELS-1:0] adj;
  logic                out_valid;
  logic [VC_W-1:0]     out_vc;
  logic [1:0]          out_type;
  logic [FLIT_W-1:0]   out_flit;
  logic                credit_valid;
  logic [VC_W-1:0]     credit_vc;
  logic                err_ovf;
  logic                err_proto;

  modport master (
    output in_valid, in_vc, in_type, in_flit, dn_ready, gnt,
    input  req, adj, out_valid, out_vc, out_type, out_flit,
           credit_valid, credit_vc, err_ovf, err_proto
  );

  modport slave (
    input  in_valid, in_vc, in_type, in_flit, dn_ready, gnt,
    output req, adj, out_valid, out_vc, out_type, out_flit,
           credit_valid, credit_vc, err_ovf, err_proto
  );
endinterface

// File: rtl/noc_vc_input_buffer.sv
// Per-input-port virtual-channel flit buffer feeding the switch allocator:
// CHANNELS FIFOs, per-VC requests, pop on grant, credit return, tail-gated adj.
module noc_vc_input_buffer #(
  parameter int CHANNELS = 12,
  parameter int DEPTH    = 4,
  parameter int FLIT_W   = 64
) (
  input logic                  clk,
  input logic                  rst,
  noc_vc_input_buffer_if.slave bus
);

  localparam int VC_W  = $clog2(CHANNELS);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {PKT_IDLE, PKT_ACTIVE} pkt_state_t;

  logic [1:0]        type_mem [CHANNELS][DEPTH];
  logic [FLIT_W-1:0] flit_mem [CHANNELS][DEPTH];
  logic [PTR_W-1:0]  rd_ptr   [CHANNELS];
  logic [PTR_W-1:0]  wr_ptr   [CHANNELS];
  logic [CNT_W-1:0]  cnt      [CHANNELS];
  pkt_state_t        pkt_state[CHANNELS];

  logic [CHANNELS-1:0] req_c, adj_c, gnt_low, pop_vec, wr_vec, wr_ok, proto_bad;
  logic [VC_W-1:0]     pop_vc;
  logic                pop_any, gnt_multi;

  logic                out_valid_q, credit_valid_q, err_ovf_q, err_proto_q;
  logic [VC_W-1:0]     out_vc_q, credit_vc_q;
  logic [1:0]          out_type_q;
  logic [FLIT_W-1:0]   out_flit_q;

  always_comb begin
    req_c = '0;
    adj_c = '0;
    for (int unsigned v = 0; v < CHANNELS; v++) begin
      req_c[v] = (cnt[v] != '0) && bus.dn_ready[v];
      adj_c[v] = bus.gnt[v] && req_c[v] && type_mem[v][rd_ptr[v]][1];
    end
  end

  // Lowest set grant bit wins; it only pops if that VC is actually requesting.
  always_comb begin
    gnt_low   = bus.gnt & (~bus.gnt + CHANNELS'(1));
    gnt_multi = (bus.gnt & (bus.gnt - CHANNELS'(1))) != '0;
    pop_vec   = gnt_low & req_c;
    pop_any   = pop_vec != '0;
    pop_vc    = '0;
    wr_vec    = '0;
    wr_ok     = '0;
    proto_bad = '0;
    for (int unsigned v = 0; v < CHANNELS; v++) begin
      if (pop_vec[v]) pop_vc = VC_W'(v);
      wr_vec[v]    = bus.in_valid && (bus.in_vc == VC_W'(v));
      wr_ok[v]     = wr_vec[v] && ((cnt[v] != FULL) || pop_vec[v]);
      proto_bad[v] = wr_ok[v] && ((pkt_state[v] == PKT_IDLE) != bus.in_type[0]);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned v = 0; v < CHANNELS; v++) begin
      if (wr_ok[v]) begin
        type_mem[v][wr_ptr[v]] <= bus.in_type;
        flit_mem[v][wr_ptr[v]] <= bus.in_flit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned v = 0; v < CHANNELS; v++) begin
        rd_ptr[v]    <= '0;
        wr_ptr[v]    <= '0;
        cnt[v]       <= '0;
        pkt_state[v] <= PKT_IDLE;
      end
      out_valid_q    <= 1'b0;
      out_vc_q       <= '0;
      out_type_q     <= '0;
      out_flit_q     <= '0;
      credit_valid_q <= 1'b0;
      credit_vc_q    <= '0;
      err_ovf_q      <= 1'b0;
      err_proto_q    <= 1'b0;
    end else begin
      for (int unsigned v = 0; v < CHANNELS; v++) begin
        if (pop_vec[v]) rd_ptr[v] <= rd_ptr[v] + PTR_W'(1);
        if (wr_ok[v]) begin
          wr_ptr[v] <= wr_ptr[v] + PTR_W'(1);
          // Illegal flits still follow their own type: tail/single close, head/body open.
          pkt_state[v] <= bus.in_type[1] ? PKT_IDLE : PKT_ACTIVE;
        end
        if (wr_ok[v] && !pop_vec[v])      cnt[v] <= cnt[v] + CNT_W'(1);
        else if (!wr_ok[v] && pop_vec[v]) cnt[v] <= cnt[v] - CNT_W'(1);
      end
      out_valid_q    <= pop_any;
      credit_valid_q <= pop_any;
      if (pop_any) begin
        out_vc_q    <= pop_vc;
        out_type_q  <= type_mem[pop_vc][rd_ptr[pop_vc]];
        out_flit_q  <= flit_mem[pop_vc][rd_ptr[pop_vc]];
        credit_vc_q <= pop_vc;
      end
      err_ovf_q   <= err_ovf_q | ((wr_vec & ~wr_ok) != '0);
      err_proto_q <= err_proto_q | gnt_multi | (proto_bad != '0);
    end
  end

  assign bus.req          = req_c;
  assign bus.adj          = adj_c;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_vc       = out_vc_q;
  assign bus.out_type     = out_type_q;
  assign bus.out_flit     = out_flit_q;
  assign bus.credit_valid = credit_valid_q;
  assign bus.credit_vc    = credit_vc_q;
  assign bus.err_ovf      = err_ovf_q;
  assign bus.err_proto    = err_proto_q;

endmodule

// File: tb/tb_noc_vc_input_buffer.sv
// Bench for noc_vc_input_buffer: directed scenarios then random traffic,
// checked against a queue-per-VC packet model.
module tb_noc_vc_input_buffer;
  localparam int CH = 12;
  localparam int D  = 4;
  localparam int FW = 64;
  localparam int VW = $clog2(CH);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  noc_vc_input_buffer_if #(.CHANNELS(CH), .FLIT_W(FW)) bus ();

  noc_vc_input_buffer #(.CHANNELS(CH), .DEPTH(D), .FLIT_W(FW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stimulus
  logic          iv;
  logic [VW-1:0] ivc;
  logic [1:0]    ityp;
  logic [FW-1:0] iflit;
  logic [CH-1:0] dn, gn, rr;
  int            k, idx;

  // Reference model: one queue of {type, flit} per VC plus packet-open flag
  logic [65:0]   q [CH][$];
  bit            act [CH];
  bit            m_ovf, m_proto, m_ov;
  int            m_ovc;
  logic [1:0]    m_otype;
  logic [63:0]   m_oflit;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CH-1:0] m_req(input logic [CH-1:0] d);
    logic [CH-1:0] r;
    r = '0;
    for (int v = 0; v < CH; v++) r[v] = (q[v].size() != 0) && d[v];
    return r;
  endfunction

  task automatic drive();
    bus.in_valid = iv;
    bus.in_vc    = ivc;
    bus.in_type  = ityp;
    bus.in_flit  = iflit;
    bus.dn_ready = dn;
    bus.gnt      = gn;
  endtask

  task automatic model_clear();
    for (int v = 0; v < CH; v++) begin
      q[v].delete();
      act[v] = 1'b0;
    end
    m_ovf   = 1'b0;
    m_proto = 1'b0;
  endtask

  // One clock: starts and ends at a falling edge.
  task automatic cycle();
    logic [CH-1:0] r, a;
    logic [65:0]   e;
    int            g;
    drive();
    #1;
    r = m_req(dn);
    a = '0;
    for (int v = 0; v < CH; v++)
      if (gn[v] && r[v]) a[v] = q[v][0][65];
    chk("req", 64'(bus.req), 64'(r));
    chk("adj", 64'(bus.adj), 64'(a));
    @(posedge clk);
    g = -1;
    for (int v = CH - 1; v >= 0; v--) if (gn[v]) g = v;
    if ($countones(gn) > 1) m_proto = 1'b1;
    m_ov = 1'b0;
    if (g >= 0 && r[g]) begin
      e       = q[g].pop_front();
      m_ov    = 1'b1;
      m_ovc   = g;
      m_otype = e[65:64];
      m_oflit = e[63:0];
    end
    if (iv && int'(ivc) < CH) begin
      if (q[ivc].size() >= D) m_ovf = 1'b1;
      else begin
        if (ityp[0] == act[ivc]) m_proto = 1'b1;  // start flit while open, or continuation while closed
        act[ivc] = (ityp == 2'b01) || (ityp == 2'b00);
        q[ivc].push_back({ityp, iflit});
      end
    end
    #1;
    chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
    chk("credit_valid", 64'(bus.credit_valid), 64'(m_ov));
    if (m_ov) begin
      chk("out_vc", 64'(bus.out_vc), 64'(m_ovc));
      chk("out_type", 64'(bus.out_type), 64'(m_otype));
      chk("out_flit", bus.out_flit, m_oflit);
      chk("credit_vc", 64'(bus.credit_vc), 64'(m_ovc));
    end
    chk("err_ovf", 64'(bus.err_ovf), 64'(m_ovf));
    chk("err_proto", 64'(bus.err_proto), 64'(m_proto));
    @(negedge clk);
  endtask

  task automatic wr(input int vc, input logic [1:0] t, input logic [63:0] f, input logic [CH-1:0] g);
    iv = 1'b1; ivc = VW'(vc); ityp = t; iflit = f; gn = g;
    cycle();
    iv = 1'b0;
  endtask

  task automatic idle(input logic [CH-1:0] g);
    iv = 1'b0; gn = g;
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    iv = 1'b0; ivc = '0; ityp = 2'b00; iflit = '0; dn = '1; gn = '0;
    drive();
    model_clear();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 64'(bus.req), 64'(0));
    chk("rst_adj", 64'(bus.adj), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_credit_valid", 64'(bus.credit_valid), 64'(0));
    chk("rst_err_ovf", 64'(bus.err_ovf), 64'(0));
    chk("rst_err_proto", 64'(bus.err_proto), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    // Head on vc 3, held without grant, then granted
    wr(3, 2'b01, 64'hA5, '0);
    idle('0);
    chk("vc3_req_held", 64'(bus.req[3]), 64'(1));
    idle(CH'(1) << 3);
    chk("vc3_out_flit", bus.out_flit, 64'hA5);
    chk("vc3_out_vc", 64'(bus.out_vc), 64'(3));
    chk("vc3_out_type", 64'(bus.out_type), 64'(1));
    chk("vc3_credit_vc", 64'(bus.credit_vc), 64'(3));
    chk("vc3_req_clear", 64'(bus.req[3]), 64'(0));
    idle('0);

    // Three-flit packet on vc 5, granted back to back
    wr(5, 2'b01, 64'h5001, '0);
    wr(5, 2'b00, 64'h5002, '0);
    wr(5, 2'b10, 64'h5003, '0);
    repeat (3) idle(CH'(1) << 5);
    idle('0);

    // vc 0 at full: write with simultaneous pop is legal, write without pop drops
    for (int i = 0; i < D; i++) wr(0, 2'b11, 64'h0100 + 64'(i), '0);
    wr(0, 2'b11, 64'h01AA, CH'(1));
    chk("full_pop_write_ok", 64'(bus.err_ovf), 64'(0));
    wr(0, 2'b11, 64'h01BB, '0);
    chk("full_write_drop", 64'(bus.err_ovf), 64'(1));
    repeat (D + 1) idle(CH'(1));
    idle('0);

    // Downstream credit gating on vc 7
    dn = ~(CH'(1) << 7);
    wr(7, 2'b01, 64'h7001, '0);
    wr(7, 2'b10, 64'h7002, '0);
    idle('0);
    chk("vc7_gated", 64'(bus.req[7]), 64'(0));
    dn = '1;
    idle('0);
    chk("vc7_ungated", 64'(bus.req[7]), 64'(1));
    repeat (2) idle(CH'(1) << 7);

    // Protocol error, multi-hot grant, reset mid-packet
    wr(1, 2'b01, 64'h1001, '0);
    wr(2, 2'b00, 64'h2001, '0);
    chk("body_in_idle", 64'(bus.err_proto), 64'(1));
    wr(4, 2'b01, 64'h4001, CH'(12'b0000_0000_0110));
    chk("multi_gnt_vc", 64'(bus.out_vc), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("midrst_req", 64'(bus.req), 64'(0));
    chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("midrst_credit_valid", 64'(bus.credit_valid), 64'(0));
    chk("midrst_err_proto", 64'(bus.err_proto), 64'(0));
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    gn = '0;
    idle('0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      dn = CH'(~($urandom & $urandom));
      iv = ($urandom_range(0, 3) != 0);
      ivc = VW'($urandom_range(0, CH - 1));
      iflit = {$urandom, $urandom};
      if ($urandom_range(0, 31) == 0) ityp = 2'($urandom);
      else if (act[ivc])              ityp = $urandom_range(0, 1) ? 2'b10 : 2'b00;
      else                            ityp = $urandom_range(0, 1) ? 2'b11 : 2'b01;
      rr = m_req(dn);
      k = $urandom_range(0, 63);
      if (k == 0) gn = CH'($urandom);
      else if (k < 8) gn = CH'(1) << $urandom_range(0, CH - 1);
      else if (k < 48 && rr != '0) begin
        do idx = $urandom_range(0, CH - 1); while (!rr[idx]);
        gn = CH'(1) << idx;
      end else gn = '0;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/noc_vc_input_buffer.md
Name: noc_vc_input_buffer

Overview:
- Per-input-port virtual-channel flit buffer that sits directly upstream of the switch allocator's matrix arbiter.
- Stores incoming flits in CHANNELS independent FIFOs and drives one request bit per VC into the arbiter's req slice for this port.
- On grant, pops the head flit onto the crossbar and returns a credit upstream.
- Drives adj so arbiter priority rotates only at packet (tail) boundaries.

Parameters:
- CHANNELS, 12, virtual channels per port; also the width of this port's req/gnt/adj slice.
- DEPTH, 4, flits per VC FIFO; power of two, at least 2.
- FLIT_W, 64, flit payload width.
- VC_W, $clog2(CHANNELS), VC index width (derived, localparam).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  flit write strobe from upstream link
- in_vc  input  VC_W  target VC of incoming flit
- in_type  input  2  flit type: 00 body, 01 head, 10 tail, 11 head+tail (single-flit packet)
- in_flit  input  FLIT_W  flit payload
- dn_ready  input  CHANNELS  per-VC downstream credit available
- req  output  CHANNELS  per-VC request to arbiter
- gnt  input  CHANNELS  per-VC grant from arbiter (combinational from req)
- adj  output  CHANNELS  priority-update qualifier to arbiter
- out_valid  output  1  flit leaving on crossbar
- out_vc  output  VC_W  VC of departing flit
- out_type  output  2  type of departing flit
- out_flit  output  FLIT_W  departing payload
- credit_valid  output  1  credit return strobe to upstream
- credit_vc  output  VC_W  VC whose slot was freed
- err_ovf  output  1  sticky: write to a full VC
- err_proto  output  1  sticky: flit-type sequence violation or multi-hot gnt

Behaviour:
- Reset (rst low, async): all FIFO pointers and counts = 0; all VC states = IDLE; all outputs = 0. Storage contents are don't-care.
- Storage: CHANNELS x DEPTH entries of {type, flit}. Each VC has a read pointer, a write pointer and a count (0..DEPTH). Pointers wrap modulo DEPTH.
- Write: on in_valid, the flit is stored at VC in_vc.
  - If count[in_vc] == DEPTH, the flit is dropped, state is unchanged, and err_ovf sets.
  - A flit written into an empty VC becomes visible on req the next cycle; there is no bypass path.
- Request: req[v] = (count[v] != 0) & dn_ready[v]. It is combinational from registers and dn_ready only, with no path from gnt.
- Grant:
  - gnt is expected to be one-hot or zero.
  - If multi-hot, only the lowest-index asserted bit is honoured and err_proto sets.
  - A gnt bit for a VC with req low is ignored.
- Pop: a granted VC v pops its head entry in the same cycle.
  - out_valid, out_vc, out_type and out_flit are registered and appear on the next clock edge, one cycle after gnt.
  - out_valid is low in cycles with no honoured grant.
- Credit: credit_valid/credit_vc are registered and pulse one cycle after the pop, coincident with out_valid. They never pulse for dropped writes.
- adj[v] = gnt[v] & req[v] & (head type is tail or head+tail). It is combinational, so the arbiter's priority updates only when a packet's last flit wins.
- Same-cycle write and pop on one VC: both take effect and count is unchanged. This is legal even when count == DEPTH, because the pop frees the slot before the write; no overflow is flagged.
- Per-VC packet FSM, tracked on the write side:
  - IDLE: head -> ACTIVE; head+tail -> IDLE.
  - ACTIVE: body -> ACTIVE; tail -> IDLE.
  - Body or tail in IDLE, or head or head+tail in ACTIVE: the flit is still stored, err_proto sets, and the FSM takes the transition implied by the flit type.
- err_ovf and err_proto clear only on reset.
- Reset mid-packet: all buffered flits are discarded, no credits are returned, and every FSM returns to IDLE.

Test Plan:
- Write head (vc 3, flit 0xA5) then no gnt -> req[3] high from cycle after write; out_valid stays 0.
- gnt[3] on cycle N -> out_valid=1, out_vc=3, out_flit=0xA5, out_type=01 at N+1; credit_valid=1, credit_vc=3 at N+1; count[3]=0 and req[3]=0 at N+1.
- 3-flit packet (head, body, tail) on vc 5, granted each cycle -> adj[5]=0, 0, 1 on the three grant cycles; flits leave in order.
- Fill vc 0 with 4 flits, write a 5th with no pop -> flit dropped, err_ovf=1, count stays 4; with simultaneous gnt[0] and write at full -> no error, count 4.
- dn_ready[7]=0 with vc 7 holding 2 flits -> req[7]=0; raise dn_ready[7] -> req[7]=1 the same cycle.
- Body flit to IDLE vc 2 -> err_proto=1 and flit stored; gnt=0b000000000110 -> only vc 1 pops, err_proto=1; assert rst low mid-packet -> all req=0, out_valid=0 immediately.
